ecap5_dwbgpio: RTL

Wishbone pipelined slave GPIO peripheral for the LED/button interface of the SoC. It drives a parameterisable set of output pins from a software-writable register. It samples a set of asynchronous input pins through a synchroniser and per-pin debouncer, and latches rising-edge events in a write-1-to-clear register. It sits beside the UART and BRAM slaves on the core's memory bus, behind the SoC address decoder.

---
 rtl/ecap5_dwbgpio.sv | 108 ++++++++++
 1 files changed

// File: rtl/ecap5_dwbgpio.sv
// Wishbone pipelined GPIO slave: OUT register drives pins, inputs pass through a
// 2-flop synchroniser and per-pin debouncer, and rising edges latch into W1C flags.

module ecap5_dwbgpio_pin #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic stable_o,
  output logic rise_o
);
  logic        meta, sync;
  logic [15:0] cnt;
  logic        flip;

  // stable follows sync only after DEBOUNCE_CYCLES consecutive disagreeing samples
  assign flip   = (sync != stable_o) && (cnt == 16'(DEBOUNCE_CYCLES - 1));
  assign rise_o = flip & sync;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta     <= 1'b0;
      sync     <= 1'b0;
      cnt      <= '0;
      stable_o <= 1'b0;
    end else begin
      meta <= pin_i;
      sync <= meta;
      if (sync == stable_o) cnt <= '0;
      else if (flip) begin
        stable_o <= sync;
        cnt      <= '0;
      end else cnt <= cnt + 16'd1;
    end
  end
endmodule

module ecap5_dwbgpio #(
  parameter int NB_OUT          = 2,
  parameter int NB_IN           = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       wb_adr_i,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  input  logic              wb_cyc_i,
  output logic              wb_stall_o,
  output logic [NB_OUT-1:0] gpio_o,
  input  logic [NB_IN-1:0]  gpio_i
);
  localparam logic [1:0] ADR_OUT  = 2'd0;
  localparam logic [1:0] ADR_IN   = 2'd1;
  localparam logic [1:0] ADR_EDGE = 2'd2;

  logic [NB_OUT-1:0] out_q;
  logic [NB_IN-1:0]  stable, rise, edge_q, edge_clr;
  logic [31:0]       rd_data;
  logic              req, wr;
  logic              unused_ok;

  assign unused_ok  = ^{wb_adr_i, wb_dat_i, wb_sel_i};
  assign wb_stall_o = 1'b0;
  assign gpio_o     = out_q;
  assign req        = wb_cyc_i & wb_stb_i;
  assign wr         = req & wb_we_i & wb_sel_i[0];

  ecap5_dwbgpio_pin #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pin [NB_IN-1:0] (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .pin_i    (gpio_i),
    .stable_o (stable),
    .rise_o   (rise)
  );

  always_comb begin
    rd_data = '0;
    case (wb_adr_i[3:2])
      ADR_OUT:  rd_data[NB_OUT-1:0] = out_q;
      ADR_IN:   rd_data[NB_IN-1:0]  = stable;
      ADR_EDGE: rd_data[NB_IN-1:0]  = edge_q;
      default:  rd_data = '0;
    endcase
  end

  assign edge_clr = (wr && wb_adr_i[3:2] == ADR_EDGE) ? wb_dat_i[NB_IN-1:0] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q    <= '0;
      edge_q   <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req && !wb_we_i) ? rd_data : 32'd0;
      if (wr && wb_adr_i[3:2] == ADR_OUT) out_q <= wb_dat_i[NB_OUT-1:0];
      // a set landing on the same edge as its clear is kept
      edge_q <= (edge_q & ~edge_clr) | rise;
    end
  end
endmodule
